// File: rtl/eeprom_pkg.sv
// Shared definitions for the EEPROM access path: arbiter state encoding,
// timing defaults and fixed EEPROM addressing constants.
package eeprom_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StBusy    = 2'd1,
        StResp    = 2'd2,
        StHoldoff = 2'd3
    } arb_state_e;

    // Write-cycle holdoff (tWR) of 5 ms at 50 MHz
    localparam int unsigned WR_HOLDOFF_5MS = 250_000;
    // Transaction watchdog of 40 ms at 50 MHz
    localparam int unsigned TIMEOUT_40MS   = 2_000_000;

    localparam logic [7:0]  EEPROM_DEV_ID  = 8'hA0;

    // Base addresses of the stored profile groups
    localparam logic [15:0] PROFILE_BASE_0 = 16'h000A;
    localparam logic [15:0] PROFILE_BASE_1 = 16'h0010;
    localparam logic [15:0] PROFILE_BASE_2 = 16'h0016;
    localparam logic [15:0] PROFILE_BASE_3 = 16'h001C;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: returns the first set request bit at or
// after the pointer, wrapping around to the lowest set bit.
module rr_pick #(
    parameter int unsigned N    = 2,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    i_req,
    input  logic [IdxW-1:0] i_ptr,
    output logic            o_valid,
    output logic [IdxW-1:0] o_idx
);

    // Wrap-around fallback first, then the lowest bit at/after the pointer wins
    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                o_idx = IdxW'(k);
            end
        end
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[k] && (k >= int'(i_ptr))) begin
                o_idx = IdxW'(k);
            end
        end
    end

endmodule

// File: rtl/eeprom_access_arbiter.sv
// Round-robin arbiter sharing the i2c_control/EEPROM path between NREQ
// requesters, one byte transaction at a time, with write-cycle holdoff and a
// transaction watchdog.
module eeprom_access_arbiter
    import eeprom_pkg::*;
#(
    parameter int unsigned NREQ       = 2,
    parameter int unsigned WR_HOLDOFF = WR_HOLDOFF_5MS,
    parameter int unsigned TIMEOUT    = TIMEOUT_40MS
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    req_wr,
    input  logic [16*NREQ-1:0] req_addr,
    input  logic [8*NREQ-1:0]  req_wdata,
    output logic [NREQ-1:0]    done,
    output logic             err,
    output logic [7:0]       rdata,
    output logic             busy,
    output logic [1:0]       gnt_id,
    output logic             wrreg_req,
    output logic             rdreg_req,
    output logic [15:0]      iic_addr,
    output logic [7:0]       iic_wrdata,
    input  logic [7:0]       iic_rddata,
    input  logic             iic_rw_done
);

    localparam int unsigned IdxW  = $clog2(NREQ);
    localparam int unsigned HoldW = $clog2(WR_HOLDOFF);
    localparam int unsigned TmoW  = $clog2(TIMEOUT) + 1;

    localparam logic [HoldW-1:0] HoldLast = HoldW'(WR_HOLDOFF - 1);
    localparam logic [TmoW-1:0]  TmoLast  = TmoW'(TIMEOUT - 1);
    localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NREQ - 1);

    arb_state_e       r_state, w_state_nxt;
    logic [IdxW-1:0]  r_ptr, w_ptr_nxt;
    logic [IdxW-1:0]  r_gnt, w_gnt_nxt;
    logic             r_is_wr, w_is_wr_nxt;
    logic             r_wrreg, w_wrreg_nxt;
    logic             r_rdreg, w_rdreg_nxt;
    logic [15:0]      r_addr, w_addr_nxt;
    logic [7:0]       r_wdata, w_wdata_nxt;
    logic [7:0]       r_rdata, w_rdata_nxt;
    logic [NREQ-1:0]  r_done, w_done_nxt;
    logic             r_err, w_err_nxt;
    logic             r_busy, w_busy_nxt;
    logic [TmoW-1:0]  r_tmo, w_tmo_nxt;
    logic [HoldW-1:0] r_hold, w_hold_nxt;

    logic             w_pick_valid;
    logic [IdxW-1:0]  w_pick_idx;
    logic [15:0]      w_addr_arr  [NREQ];
    logic [7:0]       w_wdata_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_split
        assign w_addr_arr[g]  = req_addr[16*g +: 16];
        assign w_wdata_arr[g] = req_wdata[8*g +: 8];
    end

    rr_pick #(
        .N    (NREQ),
        .IdxW (IdxW)
    ) u_rr_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    // Next-state and next-output logic for the grant/transaction FSM
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = r_gnt;
        w_is_wr_nxt = r_is_wr;
        w_wrreg_nxt = r_wrreg;
        w_rdreg_nxt = r_rdreg;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_rdata_nxt = r_rdata;
        w_done_nxt  = '0;
        w_err_nxt   = 1'b0;
        w_tmo_nxt   = r_tmo;
        w_hold_nxt  = r_hold;

        case (r_state)
            StIdle: begin
                if (w_pick_valid) begin
                    // Fields are latched here; later changes by the requester are ignored
                    w_state_nxt = StBusy;
                    w_gnt_nxt   = w_pick_idx;
                    w_is_wr_nxt = req_wr[w_pick_idx];
                    w_wrreg_nxt = req_wr[w_pick_idx];
                    w_rdreg_nxt = ~req_wr[w_pick_idx];
                    w_addr_nxt  = w_addr_arr[w_pick_idx];
                    w_wdata_nxt = w_wdata_arr[w_pick_idx];
                    w_tmo_nxt   = '0;
                end
            end
            StBusy: begin
                // Completion takes priority over a coincident timeout
                if (iic_rw_done) begin
                    w_wrreg_nxt        = 1'b0;
                    w_rdreg_nxt        = 1'b0;
                    w_done_nxt[r_gnt]  = 1'b1;
                    w_state_nxt        = StResp;
                    if (!r_is_wr) begin
                        w_rdata_nxt = iic_rddata;
                    end
                end else if (r_tmo == TmoLast) begin
                    w_wrreg_nxt        = 1'b0;
                    w_rdreg_nxt        = 1'b0;
                    w_done_nxt[r_gnt]  = 1'b1;
                    w_err_nxt          = 1'b1;
                    w_state_nxt        = StResp;
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
                end
            end
            StResp: begin
                w_ptr_nxt = (r_gnt == LastIdx) ? '0 : r_gnt + 1'b1;
                // An aborted write may still have started a device write cycle
                if (r_is_wr) begin
                    w_hold_nxt  = HoldLast;
                    w_state_nxt = StHoldoff;
                end else begin
                    w_state_nxt = StIdle;
                end
            end
            StHoldoff: begin
                if (r_hold == '0) begin
                    w_state_nxt = StIdle;
                end else begin
                    w_hold_nxt = r_hold - 1'b1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        w_busy_nxt = (w_state_nxt != StIdle);
    end

    // State and registered outputs
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= StIdle;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_is_wr <= 1'b0;
            r_wrreg <= 1'b0;
            r_rdreg <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_done  <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_tmo   <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_is_wr <= w_is_wr_nxt;
            r_wrreg <= w_wrreg_nxt;
            r_rdreg <= w_rdreg_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_rdata <= w_rdata_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= w_busy_nxt;
            r_tmo   <= w_tmo_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    assign done       = r_done;
    assign err        = r_err;
    assign rdata      = r_rdata;
    assign busy       = r_busy;
    assign gnt_id     = 2'(r_gnt);
    assign wrreg_req  = r_wrreg;
    assign rdreg_req  = r_rdreg;
    assign iic_addr   = r_addr;
    assign iic_wrdata = r_wdata;

endmodule

// File: tb/tb_eeprom_access_arbiter.sv
// Self-checking bench for eeprom_access_arbiter with an i2c_control responder
// and a transaction-level reference model of grants, data and timing.
module tb_eeprom_access_arbiter;

    localparam int unsigned NREQ       = 2;
    localparam int unsigned WR_HOLDOFF = 20;
    localparam int unsigned TIMEOUT    = 100;
    localparam int unsigned RESP_DLY   = 10;
    localparam int          BOUND      = 1000;

    logic                 Clk = 1'b0;
    logic                 Reset_n = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ-1:0]      req_wr = '0;
    logic [16*NREQ-1:0]   req_addr = '0;
    logic [8*NREQ-1:0]    req_wdata = '0;
    logic [NREQ-1:0]      done;
    logic                 err;
    logic [7:0]           rdata;
    logic                 busy;
    logic [1:0]           gnt_id;
    logic                 wrreg_req;
    logic                 rdreg_req;
    logic [15:0]          iic_addr;
    logic [7:0]           iic_wrdata;
    logic [7:0]           iic_rddata = '0;
    logic                 iic_rw_done = 1'b0;

    int checks = 0;
    int errors = 0;

    // Responder latency in cycles; 0 means never answer
    int resp_delay = RESP_DLY;

    // Device contents seen by the responder, and the scoreboard's own copy
    logic [7:0] eep [int];
    logic [7:0] sb  [int];

    // Reference model state
    int         m_ptr   = 0;
    logic [7:0] m_rdata = '0;

    eeprom_access_arbiter #(
        .NREQ       (NREQ),
        .WR_HOLDOFF (WR_HOLDOFF),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .req         (req),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .done        (done),
        .err         (err),
        .rdata       (rdata),
        .busy        (busy),
        .gnt_id      (gnt_id),
        .wrreg_req   (wrreg_req),
        .rdreg_req   (rdreg_req),
        .iic_addr    (iic_addr),
        .iic_wrdata  (iic_wrdata),
        .iic_rddata  (iic_rddata),
        .iic_rw_done (iic_rw_done)
    );

    initial forever #5 Clk = ~Clk;

    function automatic logic [7:0] init_byte(logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
    endfunction

    function automatic logic [7:0] eep_rd(logic [15:0] a);
        return eep.exists(int'(a)) ? eep[int'(a)] : init_byte(a);
    endfunction

    function automatic logic [7:0] sb_rd(logic [15:0] a);
        return sb.exists(int'(a)) ? sb[int'(a)] : init_byte(a);
    endfunction

    // Round-robin rule: first pending requester at or after the pointer
    function automatic int model_pick(logic [NREQ-1:0] r, int ptr);
        for (int i = 0; i < NREQ; i++) begin
            if (r[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(int k);
        logic [NREQ-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // i2c_control model: answers resp_delay cycles after the request rises
    initial begin : responder
        int cnt;
        cnt = 0;
        forever begin
            @(negedge Clk);
            iic_rw_done = 1'b0;
            if (Reset_n && (wrreg_req || rdreg_req)) begin
                cnt++;
                if (resp_delay != 0 && cnt == resp_delay) begin
                    iic_rw_done = 1'b1;
                    if (wrreg_req) begin
                        eep[int'(iic_addr)] = iic_wrdata;
                        iic_rddata = 8'($urandom);
                    end else begin
                        iic_rddata = eep_rd(iic_addr);
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int k, input logic wr, input logic [15:0] a,
                           input logic [7:0] d);
        req_wr[k]           = wr;
        req_addr[16*k +: 16] = a;
        req_wdata[8*k +: 8]  = d;
        req[k]              = 1'b1;
    endtask

    // Negedges until a request line to i2c_control is high (0 if already high)
    task automatic wait_grant(output int n);
        n = 0;
        while (!(wrreg_req || rdreg_req) && n < BOUND) begin
            @(negedge Clk);
            n++;
        end
    endtask

    // Negedges until a done pulse is seen
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (done == '0 && n < BOUND);
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        checks++;
        if ({done, err, busy, wrreg_req, rdreg_req} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl got %b required 0", {done, err, busy, wrreg_req, rdreg_req});
        end
        checks++;
        if (gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_gnt got %0d required 0", gnt_id);
        end
        checks++;
        if (rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_rdata got %h required 00", rdata);
        end
        checks++;
        if ({iic_addr, iic_wrdata} !== 24'h0) begin
            errors++;
            $display("FAIL reset_iic got %h required 0", {iic_addr, iic_wrdata});
        end
        Reset_n = 1'b1;
        @(negedge Clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy got %b required 0", busy);
        end
    endtask

    task automatic test_single_read();
        logic [15:0] a;
        logic [7:0]  exp;
        int          n;
        a   = eeprom_pkg::PROFILE_BASE_0;
        exp = sb_rd(a);
        set_req(0, 1'b0, a, 8'($urandom));
        @(negedge Clk);
        checks++;
        if ({rdreg_req, wrreg_req} !== 2'b10) begin
            errors++;
            $display("FAIL rd_lines got %b required 10", {rdreg_req, wrreg_req});
        end
        checks++;
        if (iic_addr !== a || gnt_id !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rd_grant got addr=%h gnt=%0d busy=%b required addr=%h gnt=0 busy=1",
                     iic_addr, gnt_id, busy, a);
        end
        // Dropping req after grant must not cancel the transaction
        req[0] = 1'b0;
        wait_done(n);
        checks++;
        if (n !== int'(RESP_DLY)) begin
            errors++;
            $display("FAIL rd_latency got %0d required %0d", n, RESP_DLY);
        end
        checks++;
        if (done !== 2'b01 || err !== 1'b0 || rdata !== exp) begin
            errors++;
            $display("FAIL rd_done got done=%b err=%b rdata=%h required done=01 err=0 rdata=%h",
                     done, err, rdata, exp);
        end
        m_rdata = exp;
        m_ptr   = 1;
        @(negedge Clk);
        checks++;
        if (done !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rd_no_holdoff got done=%b busy=%b required done=00 busy=0", done, busy);
        end
    endtask

    task automatic test_write_holdoff();
        logic [15:0] a;
        logic [7:0]  d;
        int          n;
        a = eeprom_pkg::PROFILE_BASE_1;
        d = 8'h3C;
        set_req(1, 1'b1, a, d);
        @(negedge Clk);
        checks++;
        if ({wrreg_req, rdreg_req} !== 2'b10 || iic_addr !== a || iic_wrdata !== d
            || gnt_id !== 2'd1) begin
            errors++;
            $display("FAIL wr_grant got wr=%b rd=%b addr=%h data=%h gnt=%0d required 1 0 %h %h 1",
                     wrreg_req, rdreg_req, iic_addr, iic_wrdata, gnt_id, a, d);
        end
        wait_done(n);
        checks++;
        if (n !== int'(RESP_DLY) || done !== 2'b10 || err !== 1'b0 || rdata !== m_rdata) begin
            errors++;
            $display("FAIL wr_done got n=%0d done=%b err=%b rdata=%h required %0d 10 0 %h",
                     n, done, err, rdata, RESP_DLY, m_rdata);
        end
        sb[int'(a)] = d;
        req[1] = 1'b0;
        m_ptr  = 0;
        @(negedge Clk);
        set_req(0, 1'b0, a, 8'($urandom));
        n = 1;
        while (!(wrreg_req || rdreg_req) && n < BOUND) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (n !== int'(WR_HOLDOFF) + 2) begin
            errors++;
            $display("FAIL wr_holdoff_gap got %0d required %0d", n, WR_HOLDOFF + 2);
        end
        checks++;
        if (rdreg_req !== 1'b1 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL wr_next_grant got rd=%b gnt=%0d required 1 0", rdreg_req, gnt_id);
        end
        wait_done(n);
        checks++;
        if (done !== 2'b01 || rdata !== sb_rd(a)) begin
            errors++;
            $display("FAIL wr_readback got done=%b rdata=%h required 01 %h", done, rdata, sb_rd(a));
        end
        m_rdata = sb_rd(a);
        req[0]  = 1'b0;
        m_ptr   = 1;
        @(negedge Clk);
    endtask

    task automatic test_round_robin();
        logic [15:0] f_addr [NREQ];
        logic [7:0]  f_data [NREQ];
        logic        f_wr   [NREQ];
        logic        prev_wr;
        int          n;
        int          k;
        for (int i = 0; i < NREQ; i++) begin
            f_addr[i] = 16'($urandom_range(0, 15));
            f_data[i] = 8'($urandom);
            f_wr[i]   = 1'($urandom);
            set_req(i, f_wr[i], f_addr[i], f_data[i]);
        end
        prev_wr = 1'b0;
        for (int t = 0; t < 6; t++) begin
            k = model_pick(req, m_ptr);
            wait_grant(n);
            checks++;
            if (n !== ((t == 0) ? 1 : (prev_wr ? int'(WR_HOLDOFF) + 2 : 2))) begin
                errors++;
                $display("FAIL rr_gap[%0d] got %0d required %0d", t, n,
                         (t == 0) ? 1 : (prev_wr ? int'(WR_HOLDOFF) + 2 : 2));
            end
            checks++;
            if (gnt_id !== 2'(k) || iic_addr !== f_addr[k] || wrreg_req !== f_wr[k]
                || rdreg_req !== !f_wr[k] || (f_wr[k] && iic_wrdata !== f_data[k])) begin
                errors++;
                $display("FAIL rr_grant[%0d] got gnt=%0d addr=%h wr=%b rd=%b data=%h required gnt=%0d addr=%h wr=%b data=%h",
                         t, gnt_id, iic_addr, wrreg_req, rdreg_req, iic_wrdata, k, f_addr[k],
                         f_wr[k], f_data[k]);
            end
            wait_done(n);
            if (f_wr[k]) begin
                checks++;
                if (n !== int'(RESP_DLY) || done !== onehot(k) || err !== 1'b0
                    || rdata !== m_rdata) begin
                    errors++;
                    $display("FAIL rr_wr_done[%0d] got n=%0d done=%b err=%b rdata=%h required %0d %b 0 %h",
                             t, n, done, err, rdata, RESP_DLY, onehot(k), m_rdata);
                end
                sb[int'(f_addr[k])] = f_data[k];
            end else begin
                checks++;
                if (n !== int'(RESP_DLY) || done !== onehot(k) || err !== 1'b0
                    || rdata !== sb_rd(f_addr[k])) begin
                    errors++;
                    $display("FAIL rr_rd_done[%0d] got n=%0d done=%b err=%b rdata=%h required %0d %b 0 %h",
                             t, n, done, err, rdata, RESP_DLY, onehot(k), sb_rd(f_addr[k]));
                end
                m_rdata = sb_rd(f_addr[k]);
            end
            prev_wr = f_wr[k];
            m_ptr   = (k + 1) % NREQ;
            // Requester k stays asserted with fresh fields for its next turn
            f_addr[k] = 16'($urandom_range(0, 15));
            f_data[k] = 8'($urandom);
            f_wr[k]   = 1'($urandom);
            set_req(k, f_wr[k], f_addr[k], f_data[k]);
        end
        req = '0;
        n = 0;
        while (busy !== 1'b0 && n < BOUND) begin
            @(negedge Clk);
            n++;
        end
        // A grant raced with the release must not appear once requests are gone
        @(negedge Clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_settle got busy=%b required 0", busy);
        end
    endtask

    task automatic test_timeout();
        int          k;
        int          o;
        int          n;
        logic [15:0] a;
        resp_delay = 0;
        k = m_ptr;
        o = (k + 1) % NREQ;
        a = 16'($urandom_range(0, 15));
        set_req(k, 1'b1, a, 8'($urandom));
        @(negedge Clk);
        checks++;
        if (wrreg_req !== 1'b1 || gnt_id !== 2'(k)) begin
            errors++;
            $display("FAIL to_grant got wr=%b gnt=%0d required 1 %0d", wrreg_req, gnt_id, k);
        end
        set_req(o, 1'b0, 16'($urandom_range(0, 15)), 8'($urandom));
        wait_done(n);
        checks++;
        if (n !== int'(TIMEOUT) || done !== onehot(k) || err !== 1'b1 || rdata !== m_rdata
            || {wrreg_req, rdreg_req} !== 2'b00) begin
            errors++;
            $display("FAIL to_wr_abort got n=%0d done=%b err=%b rdata=%h lines=%b required %0d %b 1 %h 00",
                     n, done, err, rdata, {wrreg_req, rdreg_req}, TIMEOUT, onehot(k), m_rdata);
        end
        req[k] = 1'b0;
        m_ptr  = o;
        wait_grant(n);
        checks++;
        if (n !== int'(WR_HOLDOFF) + 2 || gnt_id !== 2'(o) || rdreg_req !== 1'b1) begin
            errors++;
            $display("FAIL to_holdoff got gap=%0d gnt=%0d rd=%b required %0d %0d 1",
                     n, gnt_id, rdreg_req, WR_HOLDOFF + 2, o);
        end
        wait_done(n);
        checks++;
        if (n !== int'(TIMEOUT) || done !== onehot(o) || err !== 1'b1 || rdata !== m_rdata) begin
            errors++;
            $display("FAIL to_rd_abort got n=%0d done=%b err=%b rdata=%h required %0d %b 1 %h",
                     n, done, err, rdata, TIMEOUT, onehot(o), m_rdata);
        end
        req[o] = 1'b0;
        m_ptr  = (o + 1) % NREQ;
        @(negedge Clk);
        resp_delay = RESP_DLY;
    endtask

    task automatic test_reset_mid_busy();
        logic [15:0] a0;
        logic [15:0] a1;
        logic        saw_done;
        int          n;
        set_req(1, 1'b1, 16'($urandom_range(0, 15)), 8'($urandom));
        @(negedge Clk);
        checks++;
        if (wrreg_req !== 1'b1 || gnt_id !== 2'd1) begin
            errors++;
            $display("FAIL rst_pre_grant got wr=%b gnt=%0d required 1 1", wrreg_req, gnt_id);
        end
        repeat (3) @(negedge Clk);
        #2;
        Reset_n = 1'b0;
        req     = '0;
        #1;
        checks++;
        if (wrreg_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_async_wrreg got %b required 0", wrreg_req);
        end
        checks++;
        if ({done, err, busy, rdreg_req, gnt_id, rdata, iic_addr, iic_wrdata} !== '0) begin
            errors++;
            $display("FAIL rst_outputs got %h required 0",
                     {done, err, busy, rdreg_req, gnt_id, rdata, iic_addr, iic_wrdata});
        end
        saw_done = 1'b0;
        repeat (2) begin
            @(negedge Clk);
            saw_done = saw_done | (done != '0);
        end
        Reset_n = 1'b1;
        m_ptr   = 0;
        m_rdata = '0;
        a0 = 16'($urandom_range(0, 15));
        a1 = 16'($urandom_range(0, 15));
        set_req(0, 1'b0, a0, 8'($urandom));
        set_req(1, 1'b0, a1, 8'($urandom));
        wait_grant(n);
        saw_done = saw_done | (done != '0);
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_done got a done pulse required none");
        end
        checks++;
        if (n !== 1 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL rst_ptr got latency=%0d gnt=%0d required 1 0", n, gnt_id);
        end
        wait_done(n);
        checks++;
        if (done !== 2'b01 || err !== 1'b0 || rdata !== sb_rd(a0)) begin
            errors++;
            $display("FAIL rst_rd0 got done=%b err=%b rdata=%h required 01 0 %h",
                     done, err, rdata, sb_rd(a0));
        end
        req[0] = 1'b0;
        wait_grant(n);
        checks++;
        if (n !== 2 || gnt_id !== 2'd1) begin
            errors++;
            $display("FAIL rst_next got gap=%0d gnt=%0d required 2 1", n, gnt_id);
        end
        wait_done(n);
        checks++;
        if (done !== 2'b10 || rdata !== sb_rd(a1)) begin
            errors++;
            $display("FAIL rst_rd1 got done=%b rdata=%h required 10 %h", done, rdata, sb_rd(a1));
        end
        m_rdata = sb_rd(a1);
        req     = '0;
        m_ptr   = 0;
        @(negedge Clk);
    endtask

    task automatic test_coincide();
        logic [15:0] a;
        int          n;
        int          k;
        resp_delay = TIMEOUT;
        k = m_ptr;
        a = 16'($urandom_range(0, 15));
        set_req(k, 1'b0, a, 8'($urandom));
        @(negedge Clk);
        checks++;
        if (rdreg_req !== 1'b1 || gnt_id !== 2'(k)) begin
            errors++;
            $display("FAIL co_grant got rd=%b gnt=%0d required 1 %0d", rdreg_req, gnt_id, k);
        end
        wait_done(n);
        checks++;
        if (n !== int'(TIMEOUT) || done !== onehot(k) || err !== 1'b0 || rdata !== sb_rd(a)) begin
            errors++;
            $display("FAIL co_done got n=%0d done=%b err=%b rdata=%h required %0d %b 0 %h",
                     n, done, err, rdata, TIMEOUT, onehot(k), sb_rd(a));
        end
        m_rdata = sb_rd(a);
        req[k]  = 1'b0;
        m_ptr   = (k + 1) % NREQ;
        @(negedge Clk);
        resp_delay = RESP_DLY;
    endtask

    initial begin : main
        test_reset();
        test_single_read();
        test_write_holdoff();
        test_round_robin();
        test_timeout();
        test_reset_mid_busy();
        test_coincide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
